writeback_arbiter: RTL and testbench

//   Writeback stage directly upstream of the register file's single write port (WE3/A3/WD3).

---
 rtl/writeback_arbiter_pkg.sv | 26 ++
 rtl/writeback_arbiter_if.sv | 48 ++++
 rtl/writeback_arbiter_fifo.sv | 79 +++++++
 rtl/writeback_arbiter.sv | 110 +++++++++++
 tb/tb_writeback_arbiter.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/writeback_arbiter_pkg.sv
// Shared definitions for the writeback arbiter slice.
// Contents:
//   XLEN, REG_AW, NREGS   data width, register address width, register count
//   LL_DEPTH_DEFAULT      default long-latency FIFO depth
//   wb_req_t              one pending register write {rd, data}
//   rd_onehot()           decode a register address into a one-hot register mask
package writeback_arbiter_pkg;

    localparam int XLEN             = 32;
    localparam int REG_AW           = 5;
    localparam int NREGS            = 1 << REG_AW;
    localparam int LL_DEPTH_DEFAULT = 2;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

    function automatic logic [NREGS-1:0] rd_onehot(input logic [REG_AW-1:0] rd);
        logic [NREGS-1:0] m;
        m     = '0;
        m[rd] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/writeback_arbiter_if.sv
// Bus bundle of the writeback arbiter: in-order pipe results, long-latency
// valid/ready results, the register-file write port and the decode-stage
// forwarding taps.
//   master : the surrounding pipeline / register file (drives *_i)
//   slave  : the writeback arbiter (drives *_o)
interface writeback_arbiter_if;
    import writeback_arbiter_pkg::*;

    logic              pipe_valid_i;
    logic              pipe_we_i;
    logic [REG_AW-1:0] pipe_rd_i;
    logic [XLEN-1:0]   pipe_data_i;
    logic              pipe_stall_o;

    logic              ll_valid_i;
    logic              ll_ready_o;
    logic [REG_AW-1:0] ll_rd_i;
    logic [XLEN-1:0]   ll_data_i;
    logic [NREGS-1:0]  ll_pend_mask_o;

    logic              rf_we_o;
    logic [REG_AW-1:0] rf_addr_o;
    logic [XLEN-1:0]   rf_wdata_o;

    logic [REG_AW-1:0] rs1_i;
    logic [REG_AW-1:0] rs2_i;
    logic [XLEN-1:0]   rd1_i;
    logic [XLEN-1:0]   rd2_i;
    logic [XLEN-1:0]   rd1_o;
    logic [XLEN-1:0]   rd2_o;

    modport master (
        output pipe_valid_i, pipe_we_i, pipe_rd_i, pipe_data_i,
        output ll_valid_i, ll_rd_i, ll_data_i,
        output rs1_i, rs2_i, rd1_i, rd2_i,
        input  pipe_stall_o, ll_ready_o, ll_pend_mask_o,
        input  rf_we_o, rf_addr_o, rf_wdata_o, rd1_o, rd2_o
    );

    modport slave (
        input  pipe_valid_i, pipe_we_i, pipe_rd_i, pipe_data_i,
        input  ll_valid_i, ll_rd_i, ll_data_i,
        input  rs1_i, rs2_i, rd1_i, rd2_i,
        output pipe_stall_o, ll_ready_o, ll_pend_mask_o,
        output rf_we_o, rf_addr_o, rf_wdata_o, rd1_o, rd2_o
    );

endinterface

// File: rtl/writeback_arbiter_fifo.sv
// Small strict-order FIFO of pending long-latency register writes.
// Ports:
//   clk, rst       clock, synchronous active-high reset (empties the FIFO)
//   push_i         write push_req_i at the tail (caller guarantees !full_o)
//   push_req_i     entry to push
//   pop_i          drop the head entry (caller guarantees !empty_o)
//   head_o         current head entry
//   full_o/empty_o occupancy flags from the registered count
//   pend_mask_o    bit r set iff some live entry targets register r
module writeback_arbiter_fifo
    import writeback_arbiter_pkg::*;
#(
    parameter int DEPTH = LL_DEPTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  wb_req_t          push_req_i,
    input  logic             pop_i,
    output wb_req_t          head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [NREGS-1:0] pend_mask_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_req_t            mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic [NREGS-1:0]   entry_mask [DEPTH];

    // Storage carries no reset: only entries inside [rd_ptr, rd_ptr+count) are live.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_req_i;
        end
    end

    // DEPTH is a power of two, so pointer wrap is plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_i);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_i);
        count_d  = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

    // A slot is live when its distance from the head is below the count.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        localparam logic [PTR_W-1:0] IDX = PTR_W'(gi);
        logic [PTR_W-1:0] offset;
        assign offset         = IDX - rd_ptr_q;
        assign entry_mask[gi] = ({1'b0, offset} < count_q) ? rd_onehot(mem_q[gi].rd) : '0;
    end

    always_comb begin
        pend_mask_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pend_mask_o = pend_mask_o | entry_mask[i];
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback arbiter feeding the register file's single write port.
// Merges in-order pipe results with long-latency results (buffered in a small
// FIFO) into one registered write per cycle and forwards the write being
// committed to the decode-stage operands.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   bus        writeback_arbiter_if.slave (pipe, ll handshake, rf write, forwarding)
// Selection priority each cycle: pipe write, FIFO head, ll cut-through.
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int LL_DEPTH = LL_DEPTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    writeback_arbiter_if.slave bus
);
    logic              sel_pipe, sel_pop, sel_cut;
    logic              ll_fire, ll_useful, do_push;
    logic              fifo_full, fifo_empty;
    wb_req_t           fifo_head;
    wb_req_t           ll_req;

    logic              rf_we_q,    rf_we_d;
    logic [REG_AW-1:0] rf_addr_q,  rf_addr_d;
    logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;

    assign ll_req = '{rd: bus.ll_rd_i, data: bus.ll_data_i};

    // Handshake flags come from registered occupancy only.
    assign bus.ll_ready_o   = !rst && !fifo_full;
    assign bus.pipe_stall_o = !rst && fifo_full;

    assign ll_fire   = bus.ll_valid_i && bus.ll_ready_o;
    assign ll_useful = ll_fire && (bus.ll_rd_i != '0);

    assign sel_pipe = bus.pipe_valid_i && bus.pipe_we_i && (bus.pipe_rd_i != '0);
    assign sel_pop  = !sel_pipe && !fifo_empty;
    assign sel_cut  = !sel_pipe && fifo_empty && ll_useful;
    // rd=0 results are accepted but never stored.
    assign do_push  = ll_useful && !sel_cut;

    writeback_arbiter_fifo #(.DEPTH(LL_DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (do_push),
        .push_req_i  (ll_req),
        .pop_i       (sel_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .pend_mask_o (bus.ll_pend_mask_o)
    );

    // Address/data hold when idle so the write port only toggles on real writes.
    always_comb begin
        rf_we_d    = 1'b0;
        rf_addr_d  = rf_addr_q;
        rf_wdata_d = rf_wdata_q;
        if (sel_pipe) begin
            rf_we_d    = 1'b1;
            rf_addr_d  = bus.pipe_rd_i;
            rf_wdata_d = bus.pipe_data_i;
        end else if (sel_pop) begin
            rf_we_d    = 1'b1;
            rf_addr_d  = fifo_head.rd;
            rf_wdata_d = fifo_head.data;
        end else if (sel_cut) begin
            rf_we_d    = 1'b1;
            rf_addr_d  = bus.ll_rd_i;
            rf_wdata_d = bus.ll_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we_q    <= 1'b0;
            rf_addr_q  <= '0;
            rf_wdata_q <= '0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_addr_q  <= rf_addr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign bus.rf_we_o    = rf_we_q;
    assign bus.rf_addr_o  = rf_addr_q;
    assign bus.rf_wdata_o = rf_wdata_q;

    // The register file commits at the end of this cycle, so the decode read
    // would otherwise see the stale value.
    function automatic logic [XLEN-1:0] fwd(input logic [REG_AW-1:0] rs,
                                            input logic [XLEN-1:0]   rd_rf);
        if (rs == '0)                          return '0;
        else if (rf_we_q && rf_addr_q == rs)   return rf_wdata_q;
        else                                   return rd_rf;
    endfunction

    assign bus.rd1_o = fwd(bus.rs1_i, bus.rd1_i);
    assign bus.rd2_o = fwd(bus.rs2_i, bus.rd2_i);

    // Pipe wins even on this violation; the check flags the upstream bug.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(bus.pipe_valid_i && bus.pipe_stall_o));
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
module tb_writeback_arbiter;
    import writeback_arbiter_pkg::*;

    localparam int D = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    writeback_arbiter_if bus();

    writeback_arbiter #(.LL_DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: pending ll writes as an ordered queue, plus the write
    // that the register-file port currently presents.
    wb_req_t           q[$];
    logic              exp_we   = 1'b0;
    logic [REG_AW-1:0] exp_addr = '0;
    logic [XLEN-1:0]   exp_data = '0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Inputs are applied just after a falling edge; outputs settle 1 time unit later.
    task automatic drive(input logic r, input logic pv, input logic pw,
                         input logic [REG_AW-1:0] prd, input logic [XLEN-1:0] pd,
                         input logic lv, input logic [REG_AW-1:0] lrd,
                         input logic [XLEN-1:0] ld);
        rst              = r;
        bus.pipe_valid_i = pv;
        bus.pipe_we_i    = pw;
        bus.pipe_rd_i    = prd;
        bus.pipe_data_i  = pd;
        bus.ll_valid_i   = lv;
        bus.ll_rd_i      = lrd;
        bus.ll_data_i    = ld;
        bus.rs1_i        = '0;
        bus.rs2_i        = '0;
        bus.rd1_i        = '0;
        bus.rd2_i        = '0;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    function automatic logic [XLEN-1:0] exp_fwd(input logic [REG_AW-1:0] rs,
                                                 input logic [XLEN-1:0] rd_rf);
        if (rs == 0) return '0;
        if (exp_we && exp_addr == rs) return exp_data;
        return rd_rf;
    endfunction

    task automatic model_compare();
        logic [NREGS-1:0] m;
        m = '0;
        foreach (q[i]) m[q[i].rd] = 1'b1;
        chk("rf_we",     bus.rf_we_o,        exp_we);
        chk("rf_addr",   bus.rf_addr_o,      exp_addr);
        chk("rf_wdata",  bus.rf_wdata_o,     exp_data);
        chk("ll_ready",  bus.ll_ready_o,     !rst && q.size() < D);
        chk("stall",     bus.pipe_stall_o,   !rst && q.size() == D);
        chk("pend_mask", bus.ll_pend_mask_o, m);
        chk("rd1",       bus.rd1_o,          exp_fwd(bus.rs1_i, bus.rd1_i));
        chk("rd2",       bus.rd2_o,          exp_fwd(bus.rs2_i, bus.rd2_i));
        if (bus.rf_we_o) $display("wb  x%0d <= %08h", bus.rf_addr_o, bus.rf_wdata_o);
    endtask

    task automatic model_step();
        logic    fire;
        wb_req_t ll;
        ll   = '{rd: bus.ll_rd_i, data: bus.ll_data_i};
        fire = bus.ll_valid_i && q.size() < D && bus.ll_rd_i != 0;
        if (rst) begin
            q.delete();
            exp_we = 0; exp_addr = '0; exp_data = '0;
        end else if (bus.pipe_valid_i && bus.pipe_we_i && bus.pipe_rd_i != 0) begin
            exp_we = 1; exp_addr = bus.pipe_rd_i; exp_data = bus.pipe_data_i;
            if (fire) q.push_back(ll);
        end else if (q.size() > 0) begin
            wb_req_t h;
            h = q.pop_front();
            exp_we = 1; exp_addr = h.rd; exp_data = h.data;
            if (fire) q.push_back(ll);
        end else if (fire) begin
            exp_we = 1; exp_addr = ll.rd; exp_data = ll.data;
        end else begin
            exp_we = 0;
        end
    endtask

    task automatic tick();
        model_compare();
        model_step();
        @(negedge clk);
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        @(negedge clk);

        // Reset with ll_valid held high
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 5'd3, 32'h33);
            chk("t1_we", bus.rf_we_o, 1'b0);
            chk("t1_ready", bus.ll_ready_o, 1'b0);
            tick();
        end
        idle();
        chk("t1_ready_rel", bus.ll_ready_o, 1'b1);
        chk("t1_mask", bus.ll_pend_mask_o, 32'h0);
        tick();

        // Pipe write and rd=0 pipe write
        drive(1'b0, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
        tick();
        idle();
        chk("t2_we", bus.rf_we_o, 1'b1);
        chk("t2_addr", bus.rf_addr_o, 5'd5);
        chk("t2_data", bus.rf_wdata_o, 32'hDEADBEEF);
        tick();
        drive(1'b0, 1'b1, 1'b1, 5'd0, 32'h1234, 1'b0, '0, '0);
        tick();
        idle();
        chk("t2_rd0_we", bus.rf_we_o, 1'b0);
        tick();

        // Collision pipe x3 vs ll x7
        drive(1'b0, 1'b1, 1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h22);
        chk("t3_mask_n", bus.ll_pend_mask_o, 32'h0);
        tick();
        idle();
        chk("t3_addr1", bus.rf_addr_o, 5'd3);
        chk("t3_data1", bus.rf_wdata_o, 32'h11);
        chk("t3_mask1", bus.ll_pend_mask_o, 32'h80);
        tick();
        idle();
        chk("t3_we2", bus.rf_we_o, 1'b1);
        chk("t3_addr2", bus.rf_addr_o, 5'd7);
        chk("t3_data2", bus.rf_wdata_o, 32'h22);
        chk("t3_mask2", bus.ll_pend_mask_o, 32'h0);
        tick();

        // Full FIFO, drain in order, third ll result accepted late
        drive(1'b0, 1'b1, 1'b1, 5'd1, 32'hA1, 1'b1, 5'd10, 32'h10A);
        tick();
        drive(1'b0, 1'b1, 1'b1, 5'd2, 32'hA2, 1'b1, 5'd11, 32'h10B);
        tick();
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 5'd12, 32'h10C);
        chk("t4_ready_full", bus.ll_ready_o, 1'b0);
        chk("t4_stall", bus.pipe_stall_o, 1'b1);
        chk("t4_mask_full", bus.ll_pend_mask_o, 32'h0000_0C00);
        tick();
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 5'd12, 32'h10C);
        chk("t4_ready_again", bus.ll_ready_o, 1'b1);
        chk("t4_addr_a", bus.rf_addr_o, 5'd10);
        chk("t4_data_a", bus.rf_wdata_o, 32'h10A);
        tick();
        idle();
        chk("t4_addr_b", bus.rf_addr_o, 5'd11);
        chk("t4_data_b", bus.rf_wdata_o, 32'h10B);
        chk("t4_mask_c", bus.ll_pend_mask_o, 32'h0000_1000);
        tick();
        idle();
        chk("t4_addr_c", bus.rf_addr_o, 5'd12);
        chk("t4_data_c", bus.rf_wdata_o, 32'h10C);
        tick();

        // Forwarding
        drive(1'b0, 1'b1, 1'b1, 5'd9, 32'hCAFE, 1'b0, '0, '0);
        tick();
        idle();
        bus.rs1_i = 5'd9; bus.rd1_i = 32'h0;
        bus.rs2_i = 5'd0; bus.rd2_i = 32'h55;
        #1;
        chk("t5_rd1", bus.rd1_o, 32'hCAFE);
        chk("t5_rd2", bus.rd2_o, 32'h0);
        tick();

        // Reset with two buffered entries
        drive(1'b0, 1'b1, 1'b1, 5'd1, 32'h1, 1'b1, 5'd20, 32'h200);
        tick();
        drive(1'b0, 1'b1, 1'b1, 5'd2, 32'h2, 1'b1, 5'd21, 32'h201);
        tick();
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        chk("t6_mask_pre", bus.ll_pend_mask_o, 32'h0030_0000);
        tick();
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("t6_we", bus.rf_we_o, 1'b0);
            chk("t6_mask", bus.ll_pend_mask_o, 32'h0);
            chk("t6_ready", bus.ll_ready_o, 1'b1);
            tick();
        end

        // Randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            logic r, pv;
            r  = ($urandom_range(0, 99) == 0);
            pv = ($urandom_range(0, 1) == 1);
            if (!r && q.size() == D) pv = 1'b0;
            drive(r, pv, ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom,
                  ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom);
            bus.rs1_i = 5'($urandom_range(0, 7));
            bus.rs2_i = 5'($urandom_range(0, 7));
            bus.rd1_i = $urandom;
            bus.rd2_i = $urandom;
            #1;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
